// File: rtl/im_uart_loader.sv
// im_uart_loader: UART program loader that writes instruction memory and holds the CPU during a load
module im_uart_loader #(
    parameter int          CLKS_PER_BIT = 868,
    parameter int          ADDR_W       = 10,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_waddr,
    output logic [31:0]       im_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   words_loaded
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} r_state_t;
    typedef enum logic [2:0] {L_WAIT_SYNC, L_CNT_LO, L_CNT_HI, L_DATA, L_DONE} l_state_t;

    r_state_t       r_state, r_next;
    l_state_t       l_state, l_next;
    logic           rx_m, rx_s;
    logic [CW-1:0]  cnt, cnt_n;
    logic [2:0]     bit_idx, bit_n;
    logic [7:0]     sh, sh_n;
    logic           byte_valid, frame_err;
    logic [7:0]     cnt_lo;
    logic [ADDR_W:0] count_q;
    logic [1:0]     phase;
    logic [31:0]    word;
    logic [31:0]    cnt_w;
    logic           cnt_ok, do_sync, do_abort, do_bad, do_lo, do_hi, do_byte, do_wr, do_fin;

    // two-flop synchronizer for the asynchronous rx line, idling high
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) {rx_m, rx_s} <= 2'b11;
        else      {rx_m, rx_s} <= {rx, rx_m};
    end

    // byte receiver state and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= R_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            sh      <= '0;
        end else begin
            r_state <= r_next;
            cnt     <= cnt_n;
            bit_idx <= bit_n;
            sh      <= sh_n;
        end
    end

    // byte receiver next state: mid-bit sampling, glitch reject on start, stop-bit check
    always_comb begin
        r_next     = r_state;
        cnt_n      = cnt + 1'b1;
        bit_n      = bit_idx;
        sh_n       = sh;
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        case (r_state)
            R_IDLE: begin
                cnt_n  = '0;
                r_next = rx_s ? R_IDLE : R_START;
            end
            R_START: if (cnt == HALF) begin
                cnt_n  = '0;
                bit_n  = '0;
                r_next = rx_s ? R_IDLE : R_DATA;
            end
            R_DATA: if (cnt == FULL) begin
                cnt_n  = '0;
                sh_n   = {rx_s, sh[7:1]};
                bit_n  = bit_idx + 1'b1;
                r_next = (bit_idx == 3'd7) ? R_STOP : R_DATA;
            end
            default: if (cnt == FULL) begin
                cnt_n      = '0;
                byte_valid = rx_s;
                frame_err  = !rx_s;
                r_next     = R_IDLE;
            end
        endcase
    end

    // loader state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) l_state <= L_WAIT_SYNC;
        else      l_state <= l_next;
    end

    // loader next state and per-event control strobes
    always_comb begin
        cnt_w    = {21'b0, sh[2:0], cnt_lo};
        cnt_ok   = (sh[7:3] == 5'd0) && (cnt_w != 32'd0) && (cnt_w <= (32'd1 << ADDR_W));
        l_next   = l_state;
        do_sync  = 1'b0;
        do_abort = 1'b0;
        do_bad   = 1'b0;
        do_lo    = 1'b0;
        do_hi    = 1'b0;
        do_byte  = 1'b0;
        do_wr    = 1'b0;
        do_fin   = 1'b0;
        case (l_state)
            L_WAIT_SYNC, L_DONE: if (byte_valid && sh == SYNC_BYTE) begin
                do_sync = 1'b1;
                l_next  = L_CNT_LO;
            end
            L_CNT_LO: if (frame_err) begin
                do_abort = 1'b1;
                l_next   = L_WAIT_SYNC;
            end else if (byte_valid) begin
                do_lo  = 1'b1;
                l_next = L_CNT_HI;
            end
            L_CNT_HI: if (frame_err) begin
                do_abort = 1'b1;
                l_next   = L_WAIT_SYNC;
            end else if (byte_valid) begin
                do_hi  = cnt_ok;
                do_bad = !cnt_ok;
                l_next = cnt_ok ? L_DATA : L_WAIT_SYNC;
            end
            default: if (frame_err) begin
                do_abort = 1'b1;
                l_next   = L_WAIT_SYNC;
            end else if (byte_valid) begin
                do_byte = 1'b1;
                do_wr   = (phase == 2'd3);
            end else if (words_loaded == count_q) begin
                do_fin = 1'b1;
                l_next = L_DONE;
            end
        endcase
    end

    // loader datapath: count latch, word assembly, memory write, status flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            im_we        <= 1'b0;
            im_waddr     <= '0;
            im_wdata     <= '0;
            cpu_hold     <= 1'b0;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
            words_loaded <= '0;
            cnt_lo       <= '0;
            count_q      <= '0;
            phase        <= '0;
            word         <= '0;
        end else begin
            im_we <= do_wr;
            if (do_sync) begin
                cpu_hold     <= 1'b1;
                load_done    <= 1'b0;
                load_err     <= 1'b0;
                words_loaded <= '0;
            end
            if (do_abort || do_bad) begin
                load_err  <= 1'b1;
                cpu_hold  <= 1'b0;
                load_done <= 1'b0;
            end
            if (do_lo) cnt_lo <= sh;
            if (do_hi) begin
                count_q <= cnt_w[ADDR_W:0];
                phase   <= '0;
            end
            if (do_byte) begin
                word  <= {sh, word[31:8]};
                phase <= phase + 1'b1;
            end
            if (do_wr) begin
                im_waddr     <= words_loaded[ADDR_W-1:0];
                im_wdata     <= {sh, word[31:8]};
                words_loaded <= words_loaded + 1'b1;
            end
            if (do_fin) begin
                load_done <= 1'b1;
                cpu_hold  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_im_uart_loader.sv
// tb_im_uart_loader: directed UART frames against the instruction-memory loader
module tb_im_uart_loader;
    localparam int C = 16;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx = 1'b1;
    logic          im_we;
    logic [AW-1:0] im_waddr;
    logic [31:0]   im_wdata;
    logic          cpu_hold, load_done, load_err;
    logic [AW:0]   words_loaded;

    int checks = 0, failures = 0;
    int cyc = 0, wr_total = 0, last_we = 0, rises = 0, gap = 0;
    logic          hold_rise = 1'b0, pd = 1'b0;
    logic [AW-1:0] la [0:63];
    logic [31:0]   ld [0:63];

    im_uart_loader #(.CLKS_PER_BIT(C), .ADDR_W(AW), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .rst(rst), .rx(rx), .im_we(im_we), .im_waddr(im_waddr),
        .im_wdata(im_wdata), .cpu_hold(cpu_hold), .load_done(load_done),
        .load_err(load_err), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    // log writes and measure load_done rise relative to the last write
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (im_we) begin
            la[wr_total] = im_waddr;
            ld[wr_total] = im_wdata;
            wr_total = wr_total + 1;
            last_we = cyc;
        end
        if (load_done && !pd) begin
            rises = rises + 1;
            gap = cyc - last_we;
            hold_rise = cpu_hold;
        end
        pd = load_done;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (C) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (C) @(posedge clk);
        end
        rx = stop;
        repeat (C) @(posedge clk);
        rx = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic happy(input string tag);
        int base, r0;
        logic [7:0] fr [0:9];
        fr = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        base = wr_total;
        r0 = rises;
        send_byte(8'hA5, 1'b1);
        @(negedge clk);
        check({tag, "_hold_after_sync"}, 64'(cpu_hold), 64'd1);
        for (int i = 0; i < 10; i++) send_byte(fr[i], 1'b1);
        idle(6);
        @(negedge clk);
        check({tag, "_nwrites"}, 64'(wr_total - base), 64'd2);
        check({tag, "_addr0"}, 64'(la[base]), 64'd0);
        check({tag, "_data0"}, 64'(ld[base]), 64'h12345678);
        check({tag, "_addr1"}, 64'(la[base+1]), 64'd1);
        check({tag, "_data1"}, 64'(ld[base+1]), 64'hDEADBEEF);
        check({tag, "_words"}, 64'(words_loaded), 64'd2);
        check({tag, "_done"}, 64'(load_done), 64'd1);
        check({tag, "_err"}, 64'(load_err), 64'd0);
        check({tag, "_hold_end"}, 64'(cpu_hold), 64'd0);
        check({tag, "_done_rises"}, 64'(rises - r0), 64'd1);
        check({tag, "_done_gap"}, 64'(gap), 64'd1);
        check({tag, "_hold_at_done"}, 64'(hold_rise), 64'd0);
    endtask

    task automatic bad_count(input string tag, input logic [7:0] lo, input logic [7:0] hi);
        int base;
        base = wr_total;
        send_byte(8'hA5, 1'b1);
        send_byte(lo, 1'b1);
        send_byte(hi, 1'b1);
        idle(20);
        @(negedge clk);
        check({tag, "_err"}, 64'(load_err), 64'd1);
        check({tag, "_nwrites"}, 64'(wr_total - base), 64'd0);
        check({tag, "_hold"}, 64'(cpu_hold), 64'd0);
        check({tag, "_done"}, 64'(load_done), 64'd0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_we"}, 64'(im_we), 64'd0);
        check({tag, "_waddr"}, 64'(im_waddr), 64'd0);
        check({tag, "_wdata"}, 64'(im_wdata), 64'd0);
        check({tag, "_hold"}, 64'(cpu_hold), 64'd0);
        check({tag, "_done"}, 64'(load_done), 64'd0);
        check({tag, "_err"}, 64'(load_err), 64'd0);
        check({tag, "_words"}, 64'(words_loaded), 64'd0);
    endtask

    initial begin
        int base;
        #3 rst = 1'b0;
        #1 check_zero("reset");
        idle(3);
        @(negedge clk) rst = 1'b1;
        idle(5);

        happy("happy");

        base = wr_total;
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h5A, 1'b1);
        idle(10);
        @(negedge clk);
        check("junk_nwrites", 64'(wr_total - base), 64'd0);
        check("junk_hold", 64'(cpu_hold), 64'd0);
        happy("junk");

        bad_count("cnt0", 8'h00, 8'h00);
        bad_count("cnt1025", 8'h01, 8'h04);
        happy("after_bad");

        base = wr_total;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h78, 1'b1);
        send_byte(8'h56, 1'b1);
        send_byte(8'h34, 1'b0);
        idle(3 * C);
        send_byte(8'h12, 1'b1);
        send_byte(8'hEF, 1'b1);
        send_byte(8'hBE, 1'b1);
        send_byte(8'hAD, 1'b1);
        send_byte(8'hDE, 1'b1);
        idle(10);
        @(negedge clk);
        check("ferr_nwrites", 64'(wr_total - base), 64'd0);
        check("ferr_err", 64'(load_err), 64'd1);
        check("ferr_hold", 64'(cpu_hold), 64'd0);
        check("ferr_done", 64'(load_done), 64'd0);
        check("ferr_words", 64'(words_loaded), 64'd0);

        base = wr_total;
        @(negedge clk) rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        idle(3 * C);
        @(negedge clk);
        check("glitch_nwrites", 64'(wr_total - base), 64'd0);
        check("glitch_err", 64'(load_err), 64'd1);
        check("glitch_hold", 64'(cpu_hold), 64'd0);
        happy("after_glitch");

        base = wr_total;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h78, 1'b1);
        send_byte(8'h56, 1'b1);
        #2 rst = 1'b0;
        #1 check_zero("midrst");
        check("midrst_nwrites", 64'(wr_total - base), 64'd0);
        idle(4);
        @(negedge clk) rst = 1'b1;
        idle(5);
        happy("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
